// File: rtl/mp_adder_sched.sv
// Iterative N_BITS add/subtract: one LIMB-bit slice stepped LSB limb first, carry kept between cycles.
// Two requesters share the engine through a round-robin arbiter; operands are captured only at the accept edge.
module mp_adder_sched #(
  parameter int N_BITS = 400,
  parameter int LIMB   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [N_BITS-1:0] a0,
  input  logic [N_BITS-1:0] b0,
  input  logic [N_BITS-1:0] a1,
  input  logic [N_BITS-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic [N_BITS-1:0] result,
  output logic              carry_out,
  output logic              done,
  output logic              done_id
);

  localparam int NLIMB = N_BITS / LIMB;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              carry_out_q, carry_out_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done_q, done_d, done_id_q, done_id_d;
  logic              win, win_op;
  logic [LIMB:0]     limb_sum;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    result_d    = result_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    win         = 1'b0;
    win_op      = 1'b0;
    limb_sum    = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + (LIMB+1)'(carry_q);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // last_q holds the most recent winner; on contention the other side goes
          win     = (req0 && req1) ? ~last_q : req1;
          win_op  = win ? op1 : op0;
          last_d  = win;
          id_d    = win;
          a_d     = win ? a1 : a0;
          b_d     = (win ? b1 : b0) ^ {N_BITS{win_op}};
          carry_d = win_op;
          idx_d   = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands shift down so the slice always sees limb 0; sums enter at the top
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        work_d  = {limb_sum[LIMB-1:0], work_q[N_BITS-1:LIMB]};
        carry_d = limb_sum[LIMB];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          result_d    = work_d;
          carry_out_d = limb_sum[LIMB];
          done_d      = 1'b1;
          done_id_d   = id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = (state_q == RUN);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign done      = done_q;
  assign done_id   = done_id_q;

endmodule

// File: tb/tb_mp_adder_sched.sv
// Directed and random checks of mp_adder_sched against a plain-arithmetic model.
module tb_mp_adder_sched;
  localparam int N     = 400;
  localparam int NLIMB = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, carry_out, done, done_id;
  logic [N-1:0] result;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mp_adder_sched #(.N_BITS(N), .LIMB(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .result(result), .carry_out(carry_out), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry, result}: add is true sum mod 2^N; subtract carry means no borrow (a >= b)
  function automatic logic [N:0] model(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] r;
    if (!op) r = {1'b0, a} + {1'b0, b};
    else     r = {(a >= b) ? 1'b1 : 1'b0, a - b};
    return r;
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  task automatic run_op(input logic id, input logic op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic scramble, input string tag);
    logic [N:0] exp;
    logic       seen;
    int         n;
    exp = model(op, a, b);
    if (!id) begin a0 = a; b0 = b; op0 = op; req0 = 1'b1; end
    else     begin a1 = a; b1 = b; op1 = op; req1 = 1'b1; end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) seen = 1'b1;
    end
    check({tag, " gnt_seen"}, N'(seen), 1);
    check({tag, " gnt_id"}, {gnt1, gnt0}, id ? 2 : 1);
    check({tag, " busy_run"}, N'(busy), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (scramble) begin
      a0 = ~a0; b0 = rand_wide(); op0 = ~op0;
      a1 = ~a1; b1 = rand_wide(); op1 = ~op1;
    end
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, N'(seen), 1);
    check({tag, " latency"}, N'(n), NLIMB);
    check({tag, " result"}, {1'b0, result}, {1'b0, exp[N-1:0]});
    check({tag, " carry_out"}, N'(carry_out), N'(exp[N]));
    check({tag, " done_id"}, N'(done_id), N'(id));
    check({tag, " busy_done"}, N'(busy), 0);
    check({tag, " gnt_in_done"}, {gnt1, gnt0}, 0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, ones;
    logic [N:0]   exp0, exp1, expv;
    logic         seen, g;
    int           last_done, dones;

    ones = '1;
    // reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst gnt", {gnt1, gnt0}, 0);
    check("rst busy_done", {busy, done, done_id, carry_out}, 0);
    check("rst result", {1'b0, result}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 1'b0, ones, N'(1), 1'b0, "full_carry");
    run_op(1'b1, 1'b0, N'(32'h1FF), N'(1), 1'b0, "cross_limb");
    run_op(1'b0, 1'b1, N'(5), N'(7), 1'b0, "sub_borrow");
    run_op(1'b0, 1'b1, N'(7), N'(5), 1'b0, "sub_noborrow");
    run_op(1'b0, 1'b0, rand_wide(), rand_wide(), 1'b1, "isolation");

    for (int k = 0; k < 6; k++) begin
      ra = rand_wide();
      rb = (k == 5) ? ra : rand_wide();
      run_op(1'(k % 2), 1'($urandom_range(0, 1)) | (k == 5), ra, rb, 1'b0, "random");
    end

    // round-robin: both requesters held from reset release
    a0 = rand_wide(); b0 = rand_wide(); op0 = 1'b0;
    a1 = rand_wide(); b1 = rand_wide(); op1 = 1'b1;
    exp0 = model(op0, a0, b0);
    exp1 = model(op1, a1, b1);
    req0 = 1'b1; req1 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_done = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      g    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (gnt0 || gnt1) begin seen = 1'b1; g = gnt1; end
      end
      check("rr gnt_seen", N'(seen), 1);
      check("rr gnt_onehot", N'(gnt0 & gnt1), 0);
      check("rr gnt_order", N'(g), N'(k % 2));
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      check("rr done_seen", N'(seen), 1);
      expv = g ? exp1 : exp0;
      check("rr result", {expv[N], result}, {carry_out, expv[N-1:0]});
      check("rr done_id", N'(done_id), N'(g));
      if (k > 0) check("rr spacing", N'(cyc - last_done), NLIMB + 1);
      last_done = cyc;
    end
    repeat (3) @(posedge clk);
    #1;

    // reset while limb 20 is about to be processed
    a0 = rand_wide(); b0 = rand_wide(); op0 = 1'b0; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (gnt0) seen = 1'b1;
    end
    check("rstmid gnt_seen", N'(seen), 1);
    req0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid busy_before", N'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid busy", N'(busy), 0);
    check("rstmid result", {1'b0, result}, 0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rstmid no_done", N'(dones), 0);
    run_op(1'b0, 1'b0, N'(3), N'(4), 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mp_adder_sched.md
# mp_adder_sched

Iterative multi-precision add/subtract engine shared by two requesters. It owns one LIMB-bit adder slice and sequences it over N_BITS/LIMB limbs, least significant limb first, propagating carry between cycles. A round-robin arbiter chooses which requester's operands are loaded. It sits in the FPGA arithmetic datapath as the area-lean alternative to a fully unrolled wide adder.

## Interface
- N_BITS, 400: operand/result width; must be an integer multiple of LIMB.
- LIMB, 8: adder slice width; NLIMB = N_BITS/LIMB (50 by default).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0, req1  in  1  level request, held until the matching grant.
- op0, op1  in  1  0 = a+b, 1 = a−b.
- a0, b0, a1, b1  in  N_BITS  operands, stable while req is high.
- gnt0, gnt1  out  1  one-cycle pulse: operands were captured.
- busy  out  1  engine not IDLE.
- result  out  N_BITS  last completed result.
- carry_out  out  1  final carry; for subtract, 1 = no borrow (a ≥ b).
- done  out  1  one-cycle pulse: result and carry_out updated.
- done_id  out  1  requester index of the completed operation.

## Operation
- States: IDLE, RUN.
- IDLE, any req high at edge E0 (accept edge):
  - winner selected, and gnt_winner=1 for the next cycle.
  - a, b, op latched; B stored as b XOR {N_BITS{op}}; carry ← op.
  - limb index ← 0; winner id stored; state → RUN.
- Arbitration:
  - One requester active: it wins.
  - Both active: winner is the requester not granted most recently.
  - The pointer resets to favour req0 and updates only at an accept edge.
- RUN, each edge: {carry, work[idx]} ← A[idx] + B[idx] + carry; idx increments.
- Completion, at the edge processing idx = NLIMB−1:
  - result ← full working value including the final limb.
  - carry_out ← final carry; done ← 1; done_id ← id; state → IDLE.
- result/carry_out change only at completion or reset. The working register is internal.
- Arithmetic is modulo 2^N_BITS. Subtract is two's complement: a + ~b + 1.
- req still high at or after grant:
  - Ignored while in RUN.
  - If still high once back in IDLE, treated as a new request.
- Operand inputs are sampled only at the accept edge and ignored otherwise.

## Timing
- Reset values: gnt0 = gnt1 = busy = done = done_id = carry_out = 0; result = 0; state IDLE; pointer → req0.
- rst dominates req. Reset during RUN abandons the operation: no done pulse, result cleared to 0.
- Latency:
  - Accept edge E0: gnt high in cycle E0..E1.
  - Limbs are processed at edges E1..E_NLIMB.
  - done is high in cycle E_NLIMB..E_NLIMB+1, i.e. NLIMB cycles after gnt rises.
- busy is high from E0 to E_NLIMB and low in the done cycle.
- Earliest next accept is edge E_NLIMB+1, giving throughput of one op per NLIMB+1 cycles (51 by default).
- done and gnt are never high in the same cycle.
- gnt0 and gnt1 are never high together.

## Test plan
- **Full carry chain.** req0 add, a0 = 2^400−1, b0 = 1.
  - result = 0, carry_out = 1, done_id = 0.
  - done rises exactly 50 cycles after gnt0.
- **Cross-limb carry.** req1 add, a1 = 0x1FF, b1 = 0x001.
  - result = 0x200, carry_out = 0, done_id = 1.
- **Subtract with borrow.** req0 sub, a = 5, b = 7: result = 2^400−2, carry_out = 0.
  - Then a = 7, b = 5: result = 2, carry_out = 1.
- **Round-robin.** req0 and req1 both held from reset release, each with distinct operands.
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - done pulses are spaced 51 cycles apart; each done_id matches its operands.
- **Reset mid-operation.** Assert rst for 1 cycle while in RUN at limb 20.
  - No done pulse; busy = 0 and result = 0 next cycle.
  - A following req0 add of 3 + 4 yields result = 7.
- **Operand isolation.** Change a0/b0 in the cycle after gnt0.
  - result reflects the values captured at the accept edge.
